warp_issue_sched: RTL and testbench
===================================

// Module: warp_issue_sched
// PURPOSE
//  Round-robin warp issue scheduler between the per-warp ready vector (ibuffer valid & scoreboard clear)
//  and the operand-collect stage. Picks one warp per cycle with rotating priority, registers its
//  warp ID in an issue register with valid/ready handshake, and returns a one-hot pop grant to the ibuffer.
//  The fixed-priority pick (LSB highest) is reused from the existing prioritizer.
// PARAMETERS
//  NUM_WARPS  8                    number of warps / width of req and grant vectors (>=2)
//  WID_W      $clog2(NUM_WARPS)    warp ID width (derived, not overridden)
// PORTS
//  clk             in   1          clock, all state on rising edge
//  rst_n           in   1          asynchronous active-low reset
//  req_i           in   NUM_WARPS  per-warp issue request (instruction ready, hazards clear)
//  flush_i         in   1          kill issue register contents; suppress grant this cycle
//  grt_o           out  NUM_WARPS  one-hot pop grant to ibuffer; comb. from req_i/issue_ready_i/flush_i
//  issue_valid_o   out  1          issue register holds a warp
//  issue_wid_o     out  WID_W      warp ID in issue register
//  issue_ready_i   in   1          downstream accepts issue register this cycle
//  issue_stall_cnt_o out 16        backpressure stall count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: issue_valid_o=0, issue_wid_o=0, rr_ptr=NUM_WARPS-1 (warp 0 wins first), stall cnt=0; grt_o=0 while rst_n low.
//  - hi_mask = bits strictly above rr_ptr; masked = req_i & hi_mask.
//  - pick = |masked ? lowest set bit of masked : lowest set bit of req_i (wrap-around).
//  - can_load = ~issue_valid_o | issue_ready_i.
//  - load = (|req_i) & can_load & ~flush_i.
//  - grt_o = load ? pick : 0; exactly one bit or none; never asserted when no req.
//  - On load: issue_valid_o<=1, issue_wid_o<=enc(pick), rr_ptr<=enc(pick). Latency req->issue_valid 1 cycle.
//  - No load and issue_ready_i: issue_valid_o<=0; issue_wid_o holds last value.
//  - issue_ready_i=0 with valid: register, wid, rr_ptr all hold; grt_o=0 (no pop).
//  - Accept and reload same cycle allowed: back-to-back issue at 1 warp/cycle.
//  - flush_i (priority over all): issue_valid_o<=0, grt_o=0, rr_ptr unchanged; takes effect even if issue_ready_i=0.
//  - Granted warp may win again next cycle only if no other warp requests; upstream drops req_i after pop.
//  - issue_ready_i while issue_valid_o=0 is ignored.
//  - Async reset mid-transfer discards issue register; no grant during or in the cycle reset deasserts only via req_i.
// CONFIGURATION
//  WARP_ISSUE_STATS_EN defined: 16-bit counter incr. each cycle issue_valid_o & ~issue_ready_i & ~flush_i,
//    saturates at 16'hFFFF, cleared only by reset.
//  Not defined: counter not built; issue_stall_cnt_o tied to 16'h0000.
// STRUCTURE
//  Shared package/header: NUM_WARPS default, WID_W derivation, stall counter width (16).
//  Sub-module: two instances of fixed_prioritizer #(NUM_WARPS) (masked and unmasked req); local one-hot->binary encoder function.
//  Single always_ff block for issue register, rr_ptr and counter; grant logic purely combinational.
// TESTING
//  1 Reset, req_i=8'h81, ready=1 -> grt_o=8'h01, next cycle wid=0 valid=1; then grt_o=8'h80, wid=7.
//  2 req_i=8'hFF held, ready=1 -> wid sequence 0,1,..,7,0 one per cycle; grt_o one-hot every cycle.
//  3 valid=1, ready=0 for 3 cycles, req_i=8'h0C -> grt_o=0, wid stable; ready=1 -> grt_o=8'h04 same cycle, wid=2 next.
//  4 rr_ptr=7 after issuing warp 7, req_i=8'h81 -> grant warp 0 (wrap); rr_ptr=0, req_i=8'h01 -> warp 0 again.
//  5 flush_i=1 with valid=1, ready=0, req_i=8'hFF -> grt_o=0, valid=0 next cycle, rr_ptr unchanged.
//  6 STATS_EN on: ready=0 with valid for 5 cycles -> cnt=5; force 70000 stall cycles -> cnt=16'hFFFF; off -> cnt=0.

Source files
------------

// File: rtl/warp_issue_sched_pkg.sv
// Shared definitions for the warp issue scheduler: default warp count,
// warp ID width derivation and stall counter width.
package warp_issue_sched_pkg;

    localparam int NUM_WARPS_DEF = 8;
    localparam int STALL_CNT_W   = 16;

    function automatic int wid_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/warp_issue_sched_if.sv
// Issue-side bundle: ibuffer request/grant, flush, and the issue register handshake.
// master = upstream/downstream environment, slave = scheduler.
interface warp_issue_sched_if
    import warp_issue_sched_pkg::*;
#(
    parameter int NUM_WARPS = NUM_WARPS_DEF
);
    localparam int WID_W = wid_width(NUM_WARPS);

    logic [NUM_WARPS-1:0]   req_i;
    logic                   flush_i;
    logic [NUM_WARPS-1:0]   grt_o;
    logic                   issue_valid_o;
    logic [WID_W-1:0]       issue_wid_o;
    logic                   issue_ready_i;
    logic [STALL_CNT_W-1:0] issue_stall_cnt_o;

    modport master (
        output req_i, flush_i, issue_ready_i,
        input  grt_o, issue_valid_o, issue_wid_o, issue_stall_cnt_o
    );

    modport slave (
        input  req_i, flush_i, issue_ready_i,
        output grt_o, issue_valid_o, issue_wid_o, issue_stall_cnt_o
    );

endinterface

// File: rtl/warp_issue_sched_prio.sv
// Fixed-priority pick: isolates the lowest set bit of the request vector (LSB wins).
module fixed_prioritizer #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] req_i,
    output logic [WIDTH-1:0] gnt_o
);

    assign gnt_o = req_i & (~req_i + WIDTH'(1));

endmodule

// File: rtl/warp_issue_sched.sv
// Round-robin warp issue scheduler feeding a single issue register.
// Optional stall statistics counter built when WARP_ISSUE_STATS_EN is defined.
module warp_issue_sched
    import warp_issue_sched_pkg::*;
#(
    parameter int NUM_WARPS = NUM_WARPS_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    warp_issue_sched_if.slave  bus
);

    localparam int WID_W = wid_width(NUM_WARPS);

    function automatic logic [WID_W-1:0] enc(input logic [NUM_WARPS-1:0] oh);
        logic [WID_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            if (oh[i]) r = r | WID_W'(i);
        end
        return r;
    endfunction

    logic                 issue_valid_q, issue_valid_d;
    logic [WID_W-1:0]     issue_wid_q, issue_wid_d;
    logic [WID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_WARPS-1:0] hi_mask, masked, pick_masked, pick_all, pick;
    logic                 can_load, load;

    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            hi_mask[i] = (WID_W'(i) > rr_ptr_q);
        end
    end

    assign masked = bus.req_i & hi_mask;

    fixed_prioritizer #(.WIDTH(NUM_WARPS)) u_pri_masked (
        .req_i (masked),
        .gnt_o (pick_masked)
    );

    fixed_prioritizer #(.WIDTH(NUM_WARPS)) u_pri_all (
        .req_i (bus.req_i),
        .gnt_o (pick_all)
    );

    assign pick     = (|masked) ? pick_masked : pick_all;
    assign can_load = ~issue_valid_q | bus.issue_ready_i;
    // rst_n gates the pop so the ibuffer never loses an entry while reset is held
    assign load     = (|bus.req_i) & can_load & ~bus.flush_i & rst_n;
    assign bus.grt_o = load ? pick : '0;

    always_comb begin
        issue_valid_d = issue_valid_q;
        issue_wid_d   = issue_wid_q;
        rr_ptr_d      = rr_ptr_q;
        if (bus.flush_i) begin
            issue_valid_d = 1'b0;
        end else if (load) begin
            issue_valid_d = 1'b1;
            issue_wid_d   = enc(pick);
            rr_ptr_d      = enc(pick);
        end else if (bus.issue_ready_i) begin
            issue_valid_d = 1'b0;
        end
    end

`ifdef WARP_ISSUE_STATS_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (issue_valid_q && !bus.issue_ready_i && !bus.flush_i && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    assign bus.issue_stall_cnt_o = stall_cnt_q;
`else
    assign bus.issue_stall_cnt_o = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_valid_q <= 1'b0;
            issue_wid_q   <= '0;
            rr_ptr_q      <= WID_W'(NUM_WARPS - 1);
`ifdef WARP_ISSUE_STATS_EN
            stall_cnt_q   <= '0;
`endif
        end else begin
            issue_valid_q <= issue_valid_d;
            issue_wid_q   <= issue_wid_d;
            rr_ptr_q      <= rr_ptr_d;
`ifdef WARP_ISSUE_STATS_EN
            stall_cnt_q   <= stall_cnt_d;
`endif
        end
    end

    assign bus.issue_valid_o = issue_valid_q;
    assign bus.issue_wid_o   = issue_wid_q;

endmodule

// File: tb/tb_warp_issue_sched.sv
// Directed bench for warp_issue_sched; stall counter checks follow WARP_ISSUE_STATS_EN.
module tb_warp_issue_sched;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    warp_issue_sched_if #(.NUM_WARPS(8)) ifc ();

    warp_issue_sched #(.NUM_WARPS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset with requests pending: no grant, registers cleared
        rst_n = 1'b0;
        ifc.req_i = 8'h81;
        ifc.flush_i = 1'b0;
        ifc.issue_ready_i = 1'b1;
        #2;
        chk("rst_grt",   32'(ifc.grt_o), 32'h0);
        chk("rst_valid", 32'(ifc.issue_valid_o), 32'h0);
        chk("rst_wid",   32'(ifc.issue_wid_o), 32'h0);
        chk("rst_cnt",   32'(ifc.issue_stall_cnt_o), 32'h0);
        #10;
        rst_n = 1'b1;
        #1;
        // test 1: warp 0 wins first, then warp 7
        chk("t1_grt0", 32'(ifc.grt_o), 32'h01);
        cyc();
        chk("t1_valid0", 32'(ifc.issue_valid_o), 32'h1);
        chk("t1_wid0",   32'(ifc.issue_wid_o), 32'h0);
        ifc.req_i = 8'h80;
        #1;
        chk("t1_grt7", 32'(ifc.grt_o), 32'h80);
        cyc();
        chk("t1_wid7", 32'(ifc.issue_wid_o), 32'h7);

        // test 2: all requesting, rr_ptr=7 -> 0..7,0
        ifc.req_i = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            #1;
            chk("t2_grt", 32'(ifc.grt_o), 32'(1) << (k % 8));
            cyc();
            chk("t2_wid",   32'(ifc.issue_wid_o), 32'(k % 8));
            chk("t2_valid", 32'(ifc.issue_valid_o), 32'h1);
        end

        // test 3: backpressure holds everything (wid=0, rr_ptr=0)
        ifc.issue_ready_i = 1'b0;
        ifc.req_i = 8'h0C;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t3_grt_stall", 32'(ifc.grt_o), 32'h0);
            cyc();
            chk("t3_wid_stall",   32'(ifc.issue_wid_o), 32'h0);
            chk("t3_valid_stall", 32'(ifc.issue_valid_o), 32'h1);
        end
        ifc.issue_ready_i = 1'b1;
        #1;
        chk("t3_grt_release", 32'(ifc.grt_o), 32'h04);
        cyc();
        chk("t3_wid2", 32'(ifc.issue_wid_o), 32'h2);

        // test 4: issue 7, wrap to 0, then 0 alone wins again
        ifc.req_i = 8'h80;
        #1;
        chk("t4_grt7", 32'(ifc.grt_o), 32'h80);
        cyc();
        chk("t4_wid7", 32'(ifc.issue_wid_o), 32'h7);
        ifc.req_i = 8'h81;
        #1;
        chk("t4_grt_wrap", 32'(ifc.grt_o), 32'h01);
        cyc();
        chk("t4_wid0", 32'(ifc.issue_wid_o), 32'h0);
        ifc.req_i = 8'h01;
        #1;
        chk("t4_grt_again", 32'(ifc.grt_o), 32'h01);
        cyc();
        chk("t4_wid0b",  32'(ifc.issue_wid_o), 32'h0);
        // rr_ptr=0 now; move it to 2 for the flush test
        ifc.req_i = 8'h04;
        cyc();
        chk("t4_wid2", 32'(ifc.issue_wid_o), 32'h2);

        // test 5: flush with valid and ready=0
        ifc.issue_ready_i = 1'b0;
        ifc.flush_i = 1'b1;
        ifc.req_i = 8'hFF;
        #1;
        chk("t5_grt_flush", 32'(ifc.grt_o), 32'h0);
        cyc();
        chk("t5_valid_flush", 32'(ifc.issue_valid_o), 32'h0);
        chk("t5_wid_hold",    32'(ifc.issue_wid_o), 32'h2);
        ifc.flush_i = 1'b0;
        ifc.issue_ready_i = 1'b1;
        #1;
        chk("t5_grt_ptr_kept", 32'(ifc.grt_o), 32'h08);
        cyc();
        chk("t5_wid3", 32'(ifc.issue_wid_o), 32'h3);

        // drain, then ready while empty is ignored
        ifc.req_i = 8'h00;
        #1;
        chk("idle_grt", 32'(ifc.grt_o), 32'h0);
        cyc();
        chk("idle_valid", 32'(ifc.issue_valid_o), 32'h0);
        chk("idle_wid",   32'(ifc.issue_wid_o), 32'h3);
        ifc.issue_ready_i = 1'b0;
        cyc();
        chk("idle_valid2", 32'(ifc.issue_valid_o), 32'h0);

        // async reset mid-transfer: load warp 0 (rr_ptr=0), then reset
        ifc.issue_ready_i = 1'b1;
        ifc.req_i = 8'h01;
        cyc();
        chk("mr_valid", 32'(ifc.issue_valid_o), 32'h1);
        ifc.req_i = 8'hFF;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_valid_rst", 32'(ifc.issue_valid_o), 32'h0);
        chk("mr_grt_rst",   32'(ifc.grt_o), 32'h0);
        #3;
        rst_n = 1'b1;
        #1;
        chk("mr_grt_ptr_reset", 32'(ifc.grt_o), 32'h01);
        cyc();
        chk("mr_wid0", 32'(ifc.issue_wid_o), 32'h0);
        chk("mr_cnt0", 32'(ifc.issue_stall_cnt_o), 32'h0);

        // test 6: stall counter
        ifc.req_i = 8'h00;
        ifc.issue_ready_i = 1'b0;
        repeat (5) cyc();
`ifdef WARP_ISSUE_STATS_EN
        chk("t6_cnt5", 32'(ifc.issue_stall_cnt_o), 32'h5);
        ifc.flush_i = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        chk("t6_cnt_sat", 32'(ifc.issue_stall_cnt_o), 32'hFFFF);
        cyc();
        chk("t6_cnt_sat_hold", 32'(ifc.issue_stall_cnt_o), 32'hFFFF);
`else
        chk("t6_cnt_off", 32'(ifc.issue_stall_cnt_o), 32'h0);
        chk("t6_valid_stall", 32'(ifc.issue_valid_o), 32'h1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
